// File: rtl/register_file_pkg.sv
// Shared defaults and FSM encoding for the architectural register file.
// The clear sequencer only needs READY and CLEAR, so it uses a 2-bit encoding.
package register_file_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_ADDR_WIDTH = 6;
  localparam int DEFAULT_DEPTH      = 2 ** DEFAULT_ADDR_WIDTH;

  typedef enum logic [1:0] {
    READY = 2'd0,
    CLEAR = 2'd1
  } state_t;

endpackage

// File: rtl/register_file_clear_sequencer.sv
// Clear engine: walks clear_index across every entry after reset or a clear request.
// It asserts busy while it runs and emits one zeroing write per cycle.
module register_file_clear_sequencer
  import register_file_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  i_clearRequest,
  output logic                  o_busy,
  output logic                  o_clearWrite,
  output logic [ADDR_WIDTH-1:0] o_clearIndex
);

  state_t                r_state;
  state_t                w_nextState;
  logic [ADDR_WIDTH-1:0] r_clearIndex;
  logic [ADDR_WIDTH-1:0] w_nextIndex;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= CLEAR;
      r_clearIndex <= '0;
    end else begin
      r_state      <= w_nextState;
      r_clearIndex <= w_nextIndex;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_nextIndex = r_clearIndex;
    if (i_clearRequest) begin
      w_nextState = CLEAR;
      w_nextIndex = '0;
    end else begin
      case (r_state)
        READY: begin
          w_nextState = READY;
        end
        CLEAR: begin
          w_nextIndex = r_clearIndex + ADDR_WIDTH'(1);
          if (r_clearIndex == {ADDR_WIDTH{1'b1}}) begin
            w_nextState = READY;
          end
        end
        default: begin
          w_nextState = CLEAR;
          w_nextIndex = '0;
        end
      endcase
    end
  end

  // A restarting edge (reset or clear request) leaves the entries untouched.
  always_comb begin
    o_busy       = (r_state == CLEAR);
    o_clearWrite = (r_state == CLEAR) && !reset && !i_clearRequest;
    o_clearIndex = r_clearIndex;
  end

endmodule

// File: rtl/register_file.sv
// Two-read / one-write architectural register file with write-to-read bypass,
// a hardwired zero register and a sequenced clear engine.
module register_file
  import register_file_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] read_address_1,
  input  logic [ADDR_WIDTH-1:0] read_address_2,
  output logic [DATA_WIDTH-1:0] read_value_1,
  output logic [DATA_WIDTH-1:0] read_value_2,
  input  logic [ADDR_WIDTH-1:0] write_address,
  input  logic [DATA_WIDTH-1:0] write_value,
  input  logic                  write_enable,
  input  logic                  clear_request,
  output logic                  busy
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic                  w_busy;
  logic                  w_clearWrite;
  logic [ADDR_WIDTH-1:0] w_clearIndex;
  logic                  w_userWrite;
  logic                  w_bypass1;
  logic                  w_bypass2;

  register_file_clear_sequencer #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_clearSequencer (
    .clock         (clock),
    .reset         (reset),
    .i_clearRequest(clear_request),
    .o_busy        (w_busy),
    .o_clearWrite  (w_clearWrite),
    .o_clearIndex  (w_clearIndex)
  );

  assign w_userWrite = !w_busy && write_enable && !clear_request && !reset
                       && (write_address != '0);

  // Clear writes win; user writes are dropped while the engine owns the array.
  always_ff @(posedge clock) begin
    if (w_clearWrite) begin
      r_mem[w_clearIndex] <= '0;
    end else if (w_userWrite) begin
      r_mem[write_address] <= write_value;
    end
  end

  assign w_bypass1 = write_enable && (write_address == read_address_1);
  assign w_bypass2 = write_enable && (write_address == read_address_2);

  assign read_value_1 = (w_busy || read_address_1 == '0) ? '0 :
                        w_bypass1 ? write_value : r_mem[read_address_1];
  assign read_value_2 = (w_busy || read_address_2 == '0) ? '0 :
                        w_bypass2 ? write_value : r_mem[read_address_2];

  assign busy = w_busy;

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file: clear latency, bypass,
// zero register, dropped writes and clear restarts.
module tb_register_file;

  logic        clock;
  logic        reset;
  logic [5:0]  read_address_1;
  logic [5:0]  read_address_2;
  logic [31:0] read_value_1;
  logic [31:0] read_value_2;
  logic [5:0]  write_address;
  logic [31:0] write_value;
  logic        write_enable;
  logic        clear_request;
  logic        busy;

  int checks;
  int errors;

  register_file dut (
    .clock         (clock),
    .reset         (reset),
    .read_address_1(read_address_1),
    .read_address_2(read_address_2),
    .read_value_1  (read_value_1),
    .read_value_2  (read_value_2),
    .write_address (write_address),
    .write_value   (write_value),
    .write_enable  (write_enable),
    .clear_request (clear_request),
    .busy          (busy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic applyStimulus(input logic rst, input logic [5:0] ra1,
                               input logic [5:0] ra2, input logic we,
                               input logic [5:0] wa, input logic [31:0] wv,
                               input logic cr);
    reset          = rst;
    read_address_1 = ra1;
    read_address_2 = ra2;
    write_enable   = we;
    write_address  = wa;
    write_value    = wv;
    clear_request  = cr;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Counts cycles with busy high, holding inputs idle; bounded at 200.
  task automatic countBusy(output int n);
    n = 0;
    while (busy && n < 200) begin
      n++;
      tick();
    end
  endtask

  int n;

  initial begin
    checks = 0;
    errors = 0;

    // Reset for one cycle, then idle through the clear.
    applyStimulus(1'b1, 6'd5, 6'd63, 1'b0, 6'd0, 32'h0, 1'b0);
    tick();
    applyStimulus(1'b0, 6'd5, 6'd63, 1'b0, 6'd0, 32'h0, 1'b0);
    checkOutput("resetBusy", {31'd0, busy}, 32'd1);
    checkOutput("resetRead1", read_value_1, 32'h0);
    checkOutput("resetRead2", read_value_2, 32'h0);
    countBusy(n);
    checkOutput("resetClearLen", 32'(n), 32'd64);
    checkOutput("idleBusy", {31'd0, busy}, 32'd0);
    applyStimulus(1'b0, 6'd1, 6'd63, 1'b0, 6'd0, 32'h0, 1'b0);
    checkOutput("clearedRead1", read_value_1, 32'h0);
    checkOutput("clearedRead63", read_value_2, 32'h0);

    // Bypass in the commit cycle, array afterwards.
    applyStimulus(1'b0, 6'd5, 6'd0, 1'b1, 6'd5, 32'hDEADBEEF, 1'b0);
    checkOutput("bypass5", read_value_1, 32'hDEADBEEF);
    tick();
    applyStimulus(1'b0, 6'd5, 6'd5, 1'b0, 6'd0, 32'h0, 1'b0);
    checkOutput("array5a", read_value_1, 32'hDEADBEEF);
    checkOutput("array5b", read_value_2, 32'hDEADBEEF);
    tick();
    checkOutput("array5c", read_value_1, 32'hDEADBEEF);

    // Zero register ignores writes and bypass.
    applyStimulus(1'b0, 6'd0, 6'd0, 1'b1, 6'd0, 32'h12345678, 1'b0);
    checkOutput("zeroBypass1", read_value_1, 32'h0);
    checkOutput("zeroBypass2", read_value_2, 32'h0);
    tick();
    applyStimulus(1'b0, 6'd0, 6'd0, 1'b0, 6'd0, 32'h0, 1'b0);
    checkOutput("zeroRead1", read_value_1, 32'h0);
    checkOutput("zeroRead2", read_value_2, 32'h0);

    // Write 7, then clear request together with a write to 8.
    applyStimulus(1'b0, 6'd7, 6'd8, 1'b1, 6'd7, 32'hAAAA0001, 1'b0);
    tick();
    applyStimulus(1'b0, 6'd7, 6'd8, 1'b0, 6'd0, 32'h0, 1'b0);
    checkOutput("array7", read_value_1, 32'hAAAA0001);
    applyStimulus(1'b0, 6'd7, 6'd8, 1'b1, 6'd8, 32'h00000055, 1'b1);
    tick();
    applyStimulus(1'b0, 6'd7, 6'd8, 1'b0, 6'd0, 32'h0, 1'b0);
    checkOutput("reqBusy", {31'd0, busy}, 32'd1);
    checkOutput("busyRead7", read_value_1, 32'h0);
    countBusy(n);
    checkOutput("reqClearLen", 32'(n), 32'd64);
    checkOutput("after7", read_value_1, 32'h0);
    checkOutput("after8", read_value_2, 32'h0);

    // Restart at index 30; a late write to 3 during busy is dropped.
    applyStimulus(1'b0, 6'd3, 6'd3, 1'b1, 6'd3, 32'h00000033, 1'b0);
    tick();
    applyStimulus(1'b0, 6'd3, 6'd3, 1'b0, 6'd0, 32'h0, 1'b0);
    checkOutput("array3", read_value_1, 32'h00000033);
    applyStimulus(1'b0, 6'd3, 6'd3, 1'b0, 6'd0, 32'h0, 1'b1);
    tick();
    applyStimulus(1'b0, 6'd3, 6'd3, 1'b0, 6'd0, 32'h0, 1'b0);
    for (int i = 0; i < 30; i++) tick();
    applyStimulus(1'b0, 6'd3, 6'd3, 1'b0, 6'd0, 32'h0, 1'b1);
    tick();
    n = 0;
    while (busy && n < 200) begin
      if (n == 60)
        applyStimulus(1'b0, 6'd3, 6'd3, 1'b1, 6'd3, 32'hFFFFFFFF, 1'b0);
      else
        applyStimulus(1'b0, 6'd3, 6'd3, 1'b0, 6'd0, 32'h0, 1'b0);
      n++;
      tick();
    end
    applyStimulus(1'b0, 6'd3, 6'd3, 1'b0, 6'd0, 32'h0, 1'b0);
    checkOutput("restartClearLen", 32'(n), 32'd64);
    checkOutput("dropped3", read_value_1, 32'h0);

    // Back-to-back writes to 9.
    applyStimulus(1'b0, 6'd0, 6'd9, 1'b1, 6'd9, 32'h1, 1'b0);
    checkOutput("b2bFirst", read_value_2, 32'h1);
    tick();
    applyStimulus(1'b0, 6'd0, 6'd9, 1'b1, 6'd9, 32'h2, 1'b0);
    checkOutput("b2bSecond", read_value_2, 32'h2);
    tick();
    applyStimulus(1'b0, 6'd9, 6'd9, 1'b0, 6'd0, 32'h0, 1'b0);
    checkOutput("b2bHold1", read_value_1, 32'h2);
    checkOutput("b2bHold2", read_value_2, 32'h2);
    tick();
    checkOutput("b2bHold3", read_value_2, 32'h2);

    // Reset mid-clear restarts the full clear.
    applyStimulus(1'b0, 6'd9, 6'd9, 1'b0, 6'd0, 32'h0, 1'b1);
    tick();
    applyStimulus(1'b0, 6'd9, 6'd9, 1'b0, 6'd0, 32'h0, 1'b0);
    for (int i = 0; i < 10; i++) tick();
    applyStimulus(1'b1, 6'd9, 6'd9, 1'b0, 6'd0, 32'h0, 1'b0);
    tick();
    applyStimulus(1'b0, 6'd9, 6'd9, 1'b0, 6'd0, 32'h0, 1'b0);
    countBusy(n);
    checkOutput("resetMidClearLen", 32'(n), 32'd64);
    checkOutput("after9", read_value_1, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
